// File: rtl/ai_core_pkg.sv
// Shared width helpers for the Winograd add-multiply datapath.
// Upstream and downstream units derive their widths from the same functions.
package ai_core_pkg;

  function automatic int in_mul_size(input int s0, input int s1);
    return ((s0 > s1) ? s0 : s1) + 1;
  endfunction

  function automatic int pp_per_mul(input int mul_size);
    return (mul_size + 2) / 3;
  endfunction

  function automatic int pp_size(input int mul_size);
    return 2 * mul_size;
  endfunction

endpackage

// File: rtl/pp_reduce.sv
// Partial-product reducer: sums the words of one product modulo 2^PP_SIZE
// and sign-extends the result to the accumulator width.
module pp_reduce #(
  parameter int PP_SIZE    = 18,
  parameter int PP_PER_MUL = 3,
  parameter int ACC_SIZE   = 32
) (
  input  logic [PP_SIZE-1:0]         pp_i [0:PP_PER_MUL-1],
  output logic signed [ACC_SIZE-1:0] prod_o
);

  logic [PP_SIZE-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < PP_PER_MUL; i++) begin
      sum = sum + pp_i[i];
    end
    prod_o = ACC_SIZE'(signed'(sum));
  end

endmodule

// File: rtl/add_mult_acc.sv
// Dot-product accumulator behind the Winograd add-multiply unit.
// Define ADD_MULT_ACC_SAT_EN for clamping arithmetic and a sticky sat_o.
module add_mult_acc
  import ai_core_pkg::*;
#(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int ACC_SIZE  = 32,
  localparam int IN_MUL_SIZE = in_mul_size(IN_SIZE_0, IN_SIZE_1),
  localparam int PP_PER_MUL  = pp_per_mul(IN_MUL_SIZE),
  localparam int PP_SIZE     = pp_size(IN_MUL_SIZE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PP_SIZE-1:0]  pp_i [0:PP_PER_MUL-1],
  input  logic                valid_i,
  input  logic                last_i,
  input  logic [ACC_SIZE-1:0] corr_i,
  output logic                ready_o,
  output logic [ACC_SIZE-1:0] acc_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                sat_o
);

  logic signed [ACC_SIZE-1:0] prod;
  logic                       accept;

  logic                       s1_valid;
  logic                       s1_last;
  logic signed [ACC_SIZE-1:0] s1_prod;
  logic signed [ACC_SIZE-1:0] s1_corr;

  logic signed [ACC_SIZE-1:0] acc;
  logic signed [ACC_SIZE-1:0] sum;
  logic signed [ACC_SIZE-1:0] fin;

  pp_reduce #(
    .PP_SIZE   (PP_SIZE),
    .PP_PER_MUL(PP_PER_MUL),
    .ACC_SIZE  (ACC_SIZE)
  ) u_reduce (
    .pp_i  (pp_i),
    .prod_o(prod)
  );

  // Bubble after a last beat keeps the result register free for s2.
  assign ready_o = !(valid_o && !ready_i) && !(s1_valid && s1_last);
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_corr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= last_i;
        s1_prod <= prod;
        s1_corr <= last_i ? signed'(corr_i) : '0;
      end
    end
  end

`ifdef ADD_MULT_ACC_SAT_EN
  localparam logic signed [ACC_SIZE-1:0] MAXV = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] MINV = {1'b1, {(ACC_SIZE-1){1'b0}}};

  // Returns {clamped, value}.
  function automatic logic [ACC_SIZE:0] sadd(
    input logic signed [ACC_SIZE-1:0] a,
    input logic signed [ACC_SIZE-1:0] b,
    input logic                       sub
  );
    logic signed [ACC_SIZE:0] w;
    w = sub ? (a - b) : (a + b);
    if (w[ACC_SIZE] != w[ACC_SIZE-1]) begin
      return {1'b1, (w[ACC_SIZE] ? MINV : MAXV)};
    end
    return {1'b0, w[ACC_SIZE-1:0]};
  endfunction

  logic              acc_sat;
  logic              res_sat;
  logic [ACC_SIZE:0] sum_w;
  logic [ACC_SIZE:0] fin_w;

  always_comb begin
    sum_w = sadd(acc, s1_prod, 1'b0);
    fin_w = sadd(sum_w[ACC_SIZE-1:0], s1_corr, 1'b1);
    sum   = sum_w[ACC_SIZE-1:0];
    fin   = fin_w[ACC_SIZE-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_sat <= 1'b0;
      res_sat <= 1'b0;
    end else if (s1_valid) begin
      if (s1_last) begin
        acc_sat <= 1'b0;
        res_sat <= acc_sat | sum_w[ACC_SIZE] | fin_w[ACC_SIZE];
      end else begin
        acc_sat <= acc_sat | sum_w[ACC_SIZE];
      end
    end
  end

  assign sat_o = res_sat;
`else
  always_comb begin
    sum = acc + s1_prod;
    fin = sum - s1_corr;
  end

  assign sat_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc     <= '0;
      acc_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      if (s1_valid) begin
        acc <= s1_last ? '0 : sum;
      end
      if (s1_valid && s1_last) begin
        acc_o   <= fin;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_mult_acc.sv
// Directed bench for add_mult_acc at ACC_SIZE 16.
// Honors ADD_MULT_ACC_SAT_EN for the saturation expectations.
module tb_add_mult_acc;

  localparam int ACC = 16;

`ifdef ADD_MULT_ACC_SAT_EN
  localparam logic [ACC-1:0] SAT_ACC  = 16'h7FFF;
  localparam logic           SAT_FLAG = 1'b1;
`else
  localparam logic [ACC-1:0] SAT_ACC  = 16'hFA00;
  localparam logic           SAT_FLAG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [17:0]    pp [0:2];
  logic           valid_i;
  logic           last_i;
  logic [ACC-1:0] corr_i;
  logic           ready_o;
  logic [ACC-1:0] acc_o;
  logic           valid_o;
  logic           ready_i;
  logic           sat_o;

  int checks   = 0;
  int failures = 0;

  logic [ACC-1:0] q [$];

  always #5 clk = ~clk;

  add_mult_acc #(
    .IN_SIZE_0(4),
    .IN_SIZE_1(8),
    .ACC_SIZE (ACC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pp_i   (pp),
    .valid_i(valid_i),
    .last_i (last_i),
    .corr_i (corr_i),
    .ready_o(ready_o),
    .acc_o  (acc_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .sat_o  (sat_o)
  );

  always @(posedge clk) begin
    if (rst_n && valid_o && ready_i) q.push_back(acc_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [17:0] a, input logic [17:0] b,
                      input logic [17:0] c, input logic l,
                      input logic [ACC-1:0] cr);
    pp[0]   = a;
    pp[1]   = b;
    pp[2]   = c;
    last_i  = l;
    corr_i  = cr;
    valid_i = 1'b1;
    for (int n = 0; n < 20 && !ready_o; n++) step();
    chk("beat_ready", ready_o, 1);
    step();
    valid_i = 1'b0;
  endtask

  task automatic wres(input string tag, input logic [ACC-1:0] e,
                      input logic es);
    for (int n = 0; n < 20 && !valid_o; n++) step();
    chk({tag, "_valid"}, valid_o, 1);
    chk({tag, "_acc"}, acc_o, e);
    chk({tag, "_sat"}, sat_o, es);
    step();
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b1;
    last_i  = 1'b1;
    corr_i  = '0;
    ready_i = 1'b1;
    pp[0]   = 18'h00005;
    pp[1]   = '0;
    pp[2]   = '0;

    // reset with valid_i high
    repeat (3) step();
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_acc", acc_o, 0);
    chk("rst_sat", sat_o, 0);
    valid_i = 1'b0;
    rst_n   = 1'b1;
    step();
    step();
    chk("rst_noabsorb", valid_o, 0);

    // single beat: 5 + 3 - 2
    pp[0]   = 18'h00005;
    pp[1]   = 18'h00003;
    pp[2]   = '0;
    last_i  = 1'b1;
    corr_i  = 16'd2;
    valid_i = 1'b1;
    chk("single_ready0", ready_o, 1);
    step();
    valid_i = 1'b0;
    chk("single_bubble", ready_o, 0);
    chk("single_valid1", valid_o, 0);
    step();
    chk("single_valid2", valid_o, 1);
    chk("single_acc", acc_o, 16'd6);
    chk("single_ready2", ready_o, 1);
    step();
    chk("single_consumed", valid_o, 0);

    // negative and wrap: -1 + 0 + 16
    beat(18'h3FFFF, 18'h0, 18'h0, 1'b0, 16'd0);
    beat(18'h20000, 18'h20000, 18'h0, 1'b0, 16'd0);
    beat(18'h00010, 18'h0, 18'h0, 1'b1, 16'd0);
    wres("wrap", 16'd15, 1'b0);

    // backpressure
    ready_i = 1'b0;
    beat(18'h00007, 18'h0, 18'h0, 1'b1, 16'd0);
    for (int n = 0; n < 10 && !valid_o; n++) step();
    chk("bp_acc0", acc_o, 16'd7);
    pp[0]   = 18'h00002;
    last_i  = 1'b1;
    corr_i  = '0;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", ready_o, 0);
      chk("bp_valid", valid_o, 1);
      chk("bp_hold", acc_o, 16'd7);
      step();
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release", ready_o, 1);
    step();
    valid_i = 1'b0;
    chk("bp_gone", valid_o, 0);
    step();
    chk("bp_next_valid", valid_o, 1);
    chk("bp_next_acc", acc_o, 16'd2);
    step();

    // back-to-back dot products, results in order
    q.delete();
    beat(18'h00001, 18'h0, 18'h0, 1'b0, 16'd0);
    beat(18'h00002, 18'h0, 18'h0, 1'b1, 16'd0);
    beat(18'h0000A, 18'h0, 18'h0, 1'b1, 16'd1);
    for (int n = 0; n < 20 && q.size() < 2; n++) step();
    chk("b2b_count", q.size(), 2);
    chk("b2b_first", (q.size() > 0) ? q[0] : 16'hDEAD, 16'd3);
    chk("b2b_second", (q.size() > 1) ? q[1] : 16'hDEAD, 16'd9);

    // saturation: 4 x 16000
    for (int i = 0; i < 4; i++) begin
      beat(18'h03E80, 18'h0, 18'h0, i == 3, 16'd0);
    end
    wres("sat", SAT_ACC, SAT_FLAG);
    beat(18'h00001, 18'h0, 18'h0, 1'b1, 16'd0);
    wres("sat_clear", 16'd1, 1'b0);

    // reset in the middle of a dot product
    beat(18'h00005, 18'h0, 18'h0, 1'b0, 16'd0);
    beat(18'h00005, 18'h0, 18'h0, 1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_acc", acc_o, 0);
    chk("mid_rst_sat", sat_o, 0);
    step();
    rst_n = 1'b1;
    step();
    beat(18'h00007, 18'h0, 18'h0, 1'b1, 16'd0);
    wres("mid_rst_fresh", 16'd7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
